imem_loader: RTL and testbench

Boot-time program loader that writes the instruction memory the CPU core only ever reads. It accepts a byte stream over a valid/ready handshake, assembles 16-bit instruction words, and writes them to consecutive instruction-memory addresses starting at 0. It holds the CPU in reset for the duration of the load. It sits beside the core at top level, driving the instruction memory's write port (`wen`/`addr`/`data_in`).

---
 rtl/imem_loader.sv | 143 ++++++++++++++
 tb/tb_imem_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot-time loader: assembles a length-prefixed byte stream into 16-bit words and writes them
// to instruction memory from address 0 while holding the CPU in reset. Optional checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // state   | meaning
    // IDLE    | waiting for first start after reset
    // LEN_HI  | accepting length high byte
    // LEN_LO  | accepting length low byte
    // DATA_HI | accepting word high byte
    // DATA_LO | accepting word low byte, word + write enable registered
    // WRITE   | mem_wen high for this one cycle
    // CHK     | accepting checksum byte (checksum build only)
    // DONE    | load finished, done/err valid
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_WRITE, S_CHK, S_DONE
    } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t S_FIN = S_CHK;
`else
    localparam state_t S_FIN = S_DONE;
`endif

    state_t      state, state_nxt;
    logic [7:0]  len_hi;
    logic [7:0]  hi_byte;
    logic [15:0] words_left;
    logic [16:0] wr_idx;
    logic        hs;
    logic        in_range;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  chk;
`endif

    assign hs       = in_valid & in_ready;
    assign in_range = ({15'd0, wr_idx} < 32'(MAX_WORDS));
    assign busy     = (state != S_IDLE) && (state != S_DONE);
    assign cpu_hold = busy;
    assign done     = (state == S_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            S_IDLE:    if (start) state_nxt = S_LEN_HI;
            S_LEN_HI: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_LEN_LO;
            end
            S_LEN_LO: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = ({len_hi, in_data} == 16'd0) ? S_FIN : S_DATA_HI;
            end
            S_DATA_HI: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_DATA_LO;
            end
            S_DATA_LO: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_WRITE;
            end
            S_WRITE:   state_nxt = (words_left == 16'd1) ? S_FIN : S_DATA_HI;
            S_CHK: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_DONE;
            end
            S_DONE:    if (start) state_nxt = S_LEN_HI;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Words remaining is a down-counter loaded from the length; terminal count 1 ends the image.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_hi     <= '0;
            hi_byte    <= '0;
            words_left <= '0;
            wr_idx     <= '0;
            mem_wen    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            err        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk        <= '0;
`endif
        end else begin
            mem_wen <= 1'b0;
            if (start && ((state == S_IDLE) || (state == S_DONE))) begin
                wr_idx <= '0;
                err    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                chk    <= '0;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (hs && (state != S_CHK)) chk <= chk ^ in_data;
`endif
            case (state)
                S_LEN_HI:  if (hs) len_hi <= in_data;
                S_LEN_LO:  if (hs) words_left <= {len_hi, in_data};
                S_DATA_HI: if (hs) hi_byte <= in_data;
                S_DATA_LO: if (hs) begin
                    mem_wdata <= DATA_W'({hi_byte, in_data});
                    mem_addr  <= ADDR_W'(wr_idx);
                    mem_wen   <= in_range;
                    if (!in_range) err <= 1'b1;
                end
                S_WRITE: begin
                    wr_idx     <= wr_idx + 17'd1;
                    words_left <= words_left - 16'd1;
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHK:     if (hs && (in_data != chk)) err <= 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader (MAX_WORDS=2 so the overflow path is reachable).
// Build with IMEM_LOADER_CHECKSUM_EN defined to cover the checksum variant.
module tb_imem_loader;

    typedef logic [7:0] byte_q_t[$];

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        rdy;
        logic        wen;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        busy;
        logic        done;
        logic        err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, mem_wen, cpu_hold, busy, done, err;
    logic [15:0] mem_addr, mem_wdata;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] wr_addr_q[$];
    logic [15:0] wr_data_q[$];

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(16), .DATA_W(16), .MAX_WORDS(2)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
    );

    always @(negedge clk) begin
        if (mem_wen) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [7:0] xsum(input byte_q_t b);
        logic [7:0] x = 8'h00;
        foreach (b[i]) x ^= b[i];
        return x;
    endfunction

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_hold", cpu_hold, 1);
        check("start_done_clr", done, 0);
        check("start_err_clr", err, 0);
    endtask

    task automatic send_stream(input byte_q_t b, input bit toggle, output int consumed);
        int  i = 0;
        int  cyc = 0;
        bit  ph = 1'b1;
        bit  hs;
        consumed = 0;
        while (i < b.size() && cyc < 200) begin
            in_valid = toggle ? ph : 1'b1;
            in_data  = b[i];
            ph = !ph;
            hs = in_valid && in_ready;
            @(negedge clk);
            cyc++;
            if (hs) begin
                i++;
                consumed++;
            end
        end
        in_valid = 1'b0;
        if (i < b.size()) check("stream_timeout", i, b.size());
    endtask

    task automatic wait_done();
        int cyc = 0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("done_reached", done, 1);
        check("hold_released", cpu_hold, 0);
    endtask

    task automatic check_two_words(input string tag);
        check({tag, "_wr_count"}, wr_addr_q.size(), 2);
        if (wr_addr_q.size() >= 2) begin
            check({tag, "_addr0"}, wr_addr_q[0], 16'h0000);
            check({tag, "_data0"}, wr_data_q[0], 16'h1234);
            check({tag, "_addr1"}, wr_addr_q[1], 16'h0001);
            check({tag, "_data1"}, wr_data_q[1], 16'hABCD);
        end
    endtask

    initial begin
        vec_t    vecs[$];
        byte_q_t s_main, s_zero, s_ovf, s_bad;
        int      consumed;

        s_main = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        s_zero = '{8'h00, 8'h00};
        s_ovf  = '{8'h00, 8'h03, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03};
`ifdef IMEM_LOADER_CHECKSUM_EN
        s_bad = s_main;
        s_bad.push_back(8'h00);
        s_main.push_back(xsum(s_main));
        s_zero.push_back(xsum(s_zero));
        s_ovf.push_back(xsum(s_ovf));
`endif

        // Per-cycle vectors after start: inputs before the edge, outputs after it.
        vecs.push_back('{1'b1, 8'h00, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h02, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h12, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h34, 1'b0, 1'b1, 16'h0000, 16'h1234, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'hEE, 1'b1, 1'b0, 16'h0000, 16'h1234, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'hAB, 1'b1, 1'b0, 16'h0000, 16'h1234, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'hCD, 1'b0, 1'b1, 16'h0001, 16'hABCD, 1'b1, 1'b0, 1'b0});
`ifdef IMEM_LOADER_CHECKSUM_EN
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 16'h0001, 16'hABCD, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, xsum(s_main[0:5]), 1'b0, 1'b0, 16'h0001, 16'hABCD, 1'b0, 1'b1, 1'b0});
`else
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 16'h0001, 16'hABCD, 1'b0, 1'b1, 1'b0});
`endif

        #3;
        check("rst_ready", in_ready, 0);
        check("rst_wen", mem_wen, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_hold", cpu_hold, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);

        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h55;
        @(negedge clk);
        @(negedge clk);
        check("idle_ready", in_ready, 0);
        check("idle_busy", busy, 0);
        in_valid = 1'b0;

        // Table: basic 2-word load, in_valid held high (also high during WRITE)
        wr_addr_q.delete();
        wr_data_q.delete();
        do_start();
        for (int i = 0; i < vecs.size(); i++) begin
            in_valid = vecs[i].v;
            in_data  = vecs[i].d;
            @(negedge clk);
            check($sformatf("vec%0d_ready", i), in_ready, vecs[i].rdy);
            check($sformatf("vec%0d_wen", i), mem_wen, vecs[i].wen);
            check($sformatf("vec%0d_addr", i), mem_addr, vecs[i].addr);
            check($sformatf("vec%0d_wdata", i), mem_wdata, vecs[i].wdata);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
            check($sformatf("vec%0d_hold", i), cpu_hold, vecs[i].busy);
            check($sformatf("vec%0d_done", i), done, vecs[i].done);
            check($sformatf("vec%0d_err", i), err, vecs[i].err);
        end
        in_valid = 1'b0;
        check_two_words("basic");

        // Toggling valid: same image, no lost or duplicated bytes
        wr_addr_q.delete();
        wr_data_q.delete();
        do_start();
        send_stream(s_main, 1'b1, consumed);
        wait_done();
        check_two_words("toggle");
        check("toggle_err", err, 0);

        // Zero-length image
        wr_addr_q.delete();
        wr_data_q.delete();
        do_start();
        send_stream(s_zero, 1'b0, consumed);
        wait_done();
        check("zero_wr_count", wr_addr_q.size(), 0);
        check("zero_err", err, 0);

        // Overflow: third word consumed but not written
        wr_addr_q.delete();
        wr_data_q.delete();
        do_start();
        send_stream(s_ovf, 1'b0, consumed);
        wait_done();
        check("ovf_consumed", consumed, s_ovf.size());
        check("ovf_wr_count", wr_addr_q.size(), 2);
        if (wr_addr_q.size() >= 2) begin
            check("ovf_addr0", wr_addr_q[0], 16'h0000);
            check("ovf_data0", wr_data_q[0], 16'h0001);
            check("ovf_addr1", wr_addr_q[1], 16'h0001);
            check("ovf_data1", wr_data_q[1], 16'h0002);
        end
        check("ovf_err", err, 1);
        check("ovf_ready_after", in_ready, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        wr_addr_q.delete();
        wr_data_q.delete();
        do_start();
        send_stream(s_bad, 1'b0, consumed);
        wait_done();
        check_two_words("badchk");
        check("badchk_err", err, 1);
`endif

        // Asynchronous reset mid-load, then a clean reload
        wr_addr_q.delete();
        wr_data_q.delete();
        do_start();
        send_stream(s_main[0:2], 1'b0, consumed);
        #2 rst = 1'b0;
        #1;
        check("arst_ready", in_ready, 0);
        check("arst_wen", mem_wen, 0);
        check("arst_addr", mem_addr, 0);
        check("arst_wdata", mem_wdata, 0);
        check("arst_hold", cpu_hold, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_err", err, 0);
        #1 rst = 1'b1;
        @(negedge clk);
        check("arst_done_after", done, 0);
        check("arst_no_write", wr_addr_q.size(), 0);
        do_start();
        send_stream(s_main, 1'b0, consumed);
        wait_done();
        check_two_words("reload");
        check("reload_err", err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
